// File: rtl/spi_sram_frame_if.sv
// -----------------------------------------------------------------------------
// spi_sram_frame_if
// Bundles the bit-counter / mosi / miso side and the SRAM side of the
// spi_sram_frame engine into one interface.
//   slave  : the frame engine (receives bit_idx, mosi, sram_rdata;
//            drives miso, SRAM address/data/strobes and status flags)
//   master : whatever sits around the engine (bit counter, SRAM, bench)
// -----------------------------------------------------------------------------
interface spi_sram_frame_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [4:0]    bit_idx;
    logic          mosi;
    logic          miso;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic          sram_we;
    logic          sram_re;
    logic          busy;
    logic          frame_err;

    modport slave (
        input  bit_idx, mosi, sram_rdata,
        output miso, sram_addr, sram_wdata, sram_we, sram_re, busy, frame_err
    );

    modport master (
        output bit_idx, mosi, sram_rdata,
        input  miso, sram_addr, sram_wdata, sram_we, sram_re, busy, frame_err
    );
endinterface

// File: rtl/spi_sram_frame.sv
// -----------------------------------------------------------------------------
// spi_sram_frame
// SPI-slave frame engine sitting between the 5-bit sck bit counter and the
// SRAM array. Decodes a 32-bit MSB-first frame
//   idx 0-7 opcode | 8-15 address | 16-23 data | 24-31 trailer
// and issues single-cycle SRAM read/write strobes; read data goes out on miso.
// Everything runs on posedge i_sck.
//
// Ports
//   i_sck  : SPI clock
//   i_rst  : synchronous active-low reset
//   bus    : spi_sram_frame_if.slave (bit_idx, mosi, sram_rdata in;
//            miso, sram_addr, sram_wdata, sram_we, sram_re, busy, frame_err out)
//
// Build option
//   SPI_SRAM_STATUS_EN : when defined, the trailer carries a status byte
//                        {frame_err, wr_done, rd_done, frame_cnt[4:0]} on miso;
//                        otherwise miso stays 0 during the trailer.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_CMD  | shifting in the opcode (idx 0..7)
// S_ADDR | valid opcode seen, shifting in the address (idx 8..15)
// S_DATA | read: shifting SRAM data out; write: shifting data in
// S_DONE | trailer of a good frame (idx 24..31)
// S_ERR  | unknown opcode, waiting out the frame (idx 8..31)
// -----------------------------------------------------------------------------
module spi_sram_frame #(
    parameter int         AW    = 8,
    parameter int         DW    = 8,
    parameter logic [7:0] OP_RD = 8'h03,
    parameter logic [7:0] OP_WR = 8'h02
) (
    input  logic              i_sck,
    input  logic              i_rst,
    spi_sram_frame_if.slave   bus
);

    typedef enum logic [2:0] {
        S_CMD,
        S_ADDR,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t        r_state;
    logic [6:0]    r_sh;      // serial-in history; with mosi it forms a full byte
    logic [6:0]    r_out;     // remaining bits still to go out on miso
    logic          r_is_rd;
    logic          r_miso;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_we;
    logic          r_re;
    logic          r_busy;
    logic          r_err;

    logic [7:0]    w_sh_next;
    logic          w_resync;

    assign w_sh_next = {r_sh, bus.mosi};
    assign w_resync  = (bus.bit_idx == 5'd0) && (r_state != S_CMD);

`ifdef SPI_SRAM_STATUS_EN
    logic [4:0] r_cnt;
    logic [7:0] w_status;
    // The status is loaded in the trailer of a frame that is about to
    // complete, so it already describes this frame: its type and the count
    // including it.
    assign w_status = {r_err, ~r_is_rd, r_is_rd, r_cnt + 5'd1};
`endif

    always_ff @(posedge i_sck) begin
        if (!i_rst) begin
            r_state <= S_CMD;
            r_sh    <= '0;
            r_out   <= '0;
            r_is_rd <= 1'b0;
            r_miso  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
`ifdef SPI_SRAM_STATUS_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_sh   <= w_sh_next[6:0];
            r_we   <= 1'b0;
            r_re   <= 1'b0;
            r_miso <= 1'b0;

            if (w_resync) begin
                // The counter restarted mid-frame: drop the partial frame.
                // This edge's mosi is already in r_sh as opcode bit 7.
                r_state <= S_CMD;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_CMD: begin
                        if (bus.bit_idx == 5'd7) begin
                            r_busy <= 1'b1;
                            if (w_sh_next == OP_RD || w_sh_next == OP_WR) begin
                                r_state <= S_ADDR;
                                r_err   <= 1'b0;
                                r_is_rd <= (w_sh_next == OP_RD);
                            end else begin
                                r_state <= S_ERR;
                                r_err   <= 1'b1;
                            end
                        end
                    end

                    S_ADDR: begin
                        if (bus.bit_idx == 5'd15) begin
                            r_addr  <= w_sh_next[AW-1:0];
                            r_re    <= r_is_rd;
                            r_state <= S_DATA;
                        end
                    end

                    S_DATA: begin
                        if (r_is_rd) begin
                            // sram_rdata is valid on the edge after the read strobe.
                            if (bus.bit_idx == 5'd16) begin
                                r_miso <= bus.sram_rdata[7];
                                r_out  <= bus.sram_rdata[6:0];
                            end else if (bus.bit_idx >= 5'd17 && bus.bit_idx <= 5'd23) begin
                                r_miso <= r_out[6];
                                r_out  <= {r_out[5:0], 1'b0};
                            end
                        end else if (bus.bit_idx == 5'd23) begin
                            r_wdata <= w_sh_next[DW-1:0];
                            r_we    <= 1'b1;
                        end
                        if (bus.bit_idx == 5'd23) begin
                            r_state <= S_DONE;
                        end
                    end

                    S_DONE: begin
`ifdef SPI_SRAM_STATUS_EN
                        if (bus.bit_idx == 5'd24) begin
                            r_miso <= w_status[7];
                            r_out  <= w_status[6:0];
                        end else if (bus.bit_idx >= 5'd25) begin
                            r_miso <= r_out[6];
                            r_out  <= {r_out[5:0], 1'b0};
                        end
`endif
                        if (bus.bit_idx == 5'd31) begin
                            r_busy  <= 1'b0;
                            r_state <= S_CMD;
`ifdef SPI_SRAM_STATUS_EN
                            r_cnt   <= r_cnt + 5'd1;
`endif
                        end
                    end

                    S_ERR: begin
                        if (bus.bit_idx == 5'd31) begin
                            r_busy  <= 1'b0;
                            r_state <= S_CMD;
                        end
                    end

                    default: begin
                        r_state <= S_CMD;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.miso       = r_miso;
    assign bus.sram_addr  = r_addr;
    assign bus.sram_wdata = r_wdata;
    assign bus.sram_we    = r_we;
    assign bus.sram_re    = r_re;
    assign bus.busy       = r_busy;
    assign bus.frame_err  = r_err;

endmodule

// File: tb/tb_spi_sram_frame.sv
// -----------------------------------------------------------------------------
// tb_spi_sram_frame
// Drives whole 32-bit frames (optionally cut short by a counter restart or a
// reset) and compares every output after every edge against a frame-level
// model: expected values are derived from the position inside the frame and
// the frame's opcode/address/data, plus a reference copy of the SRAM.
// -----------------------------------------------------------------------------
module tb_spi_sram_frame;
    localparam logic [7:0] OP_RD = 8'h03;
    localparam logic [7:0] OP_WR = 8'h02;

    logic sck;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [7:0] sram    [256];
    logic [7:0] ref_mem [256];

    logic [7:0] m_addr;
    logic [7:0] m_wdata;
    logic       m_err;
    int         m_cnt;

    logic [7:0] got_rd;
    logic [7:0] got_st;

    spi_sram_frame_if #(.AW(8), .DW(8)) bus ();

    spi_sram_frame #(.AW(8), .DW(8), .OP_RD(OP_RD), .OP_WR(OP_WR)) dut (
        .i_sck (sck),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial sck = 1'b0;
    always #5 sck = ~sck;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Behavioural SRAM: reacts to the DUT strobes, returns data the cycle
    // after a read strobe and garbage otherwise.
    task automatic sram_update();
        if (bus.sram_we) sram[bus.sram_addr] = bus.sram_wdata;
        bus.sram_rdata = bus.sram_re ? sram[bus.sram_addr] : 8'($urandom);
    endtask

    task automatic check_zero();
        check_eq("rst_miso",  32'(bus.miso),       32'd0);
        check_eq("rst_addr",  32'(bus.sram_addr),  32'd0);
        check_eq("rst_wdata", 32'(bus.sram_wdata), 32'd0);
        check_eq("rst_we",    32'(bus.sram_we),    32'd0);
        check_eq("rst_re",    32'(bus.sram_re),    32'd0);
        check_eq("rst_busy",  32'(bus.busy),       32'd0);
        check_eq("rst_err",   32'(bus.frame_err),  32'd0);
    endtask

    // cut    : number of bits sent before the counter restarts (0 = full frame)
    // rst_at : frame index on which reset is held low (-1 = none)
    task automatic run_frame(input logic [7:0] op, input logic [7:0] addr,
                             input logic [7:0] data, input int cut, input int rst_at);
        logic [31:0] f;
        logic [7:0]  rdv;
        logic [7:0]  st;
        logic        is_rd, is_wr, valid, e_miso;
        int          last;
        f     = {op, addr, data, 8'($urandom)};
        is_rd = (op == OP_RD);
        is_wr = (op == OP_WR);
        valid = is_rd | is_wr;
        rdv   = ref_mem[addr];
        st    = {1'b0, is_wr, is_rd, 5'(m_cnt + 1)};
        last  = (cut > 0) ? cut - 1 : 31;
        for (int k = 0; k <= last; k++) begin
            bus.bit_idx = 5'(k);
            bus.mosi    = f[31-k];
            rst         = (k == rst_at) ? 1'b0 : 1'b1;
            @(posedge sck);
            #1;
            if (k == rst_at) begin
                m_addr  = 8'h00;
                m_wdata = 8'h00;
                m_err   = 1'b0;
                m_cnt   = 0;
                check_zero();
                rst = 1'b1;
                sram_update();
                return;
            end
            if (k == 7) m_err = !valid;
            if (k == 15 && valid) m_addr = addr;
            if (k == 23 && is_wr) begin
                m_wdata       = data;
                ref_mem[addr] = data;
            end
            e_miso = 1'b0;
            if (is_rd && k >= 16 && k <= 23) e_miso = rdv[23-k];
`ifdef SPI_SRAM_STATUS_EN
            if (valid && k >= 24) e_miso = st[31-k];
`endif
            check_eq("busy",  32'(bus.busy),       32'(k >= 7 && k <= 30));
            check_eq("err",   32'(bus.frame_err),  32'(m_err));
            check_eq("re",    32'(bus.sram_re),    32'(is_rd && k == 15));
            check_eq("we",    32'(bus.sram_we),    32'(is_wr && k == 23));
            check_eq("addr",  32'(bus.sram_addr),  32'(m_addr));
            check_eq("wdata", 32'(bus.sram_wdata), 32'(m_wdata));
            check_eq("miso",  32'(bus.miso),       32'(e_miso));
            if (k >= 16 && k <= 23) got_rd[23-k] = bus.miso;
            if (k >= 24) got_st[31-k] = bus.miso;
            if (k == 31 && valid) m_cnt = (m_cnt + 1) % 32;
            sram_update();
        end
    endtask

    initial begin
        logic [7:0] op;
        int         cut;
        int         rst_at;
        n_checks = 0;
        n_errors = 0;
        m_addr   = 8'h00;
        m_wdata  = 8'h00;
        m_err    = 1'b0;
        m_cnt    = 0;
        got_rd   = 8'h00;
        got_st   = 8'h00;
        for (int i = 0; i < 256; i++) begin
            sram[i]    = 8'($urandom);
            ref_mem[i] = sram[i];
        end
        rst            = 1'b0;
        bus.bit_idx    = 5'd0;
        bus.mosi       = 1'b0;
        bus.sram_rdata = 8'h00;
        repeat (2) @(posedge sck);
        #1;
        check_zero();
        rst = 1'b1;

        // write then read back the same byte; trailer status on the read
        run_frame(OP_WR, 8'h5A, 8'hC3, 0, -1);
        run_frame(OP_RD, 8'h5A, 8'h00, 0, -1);
        check_eq("rd_bits", 32'(got_rd), 32'h0000_00C3);
`ifdef SPI_SRAM_STATUS_EN
        check_eq("status", 32'(got_st), 32'h0000_0022);
`endif
        // unknown opcode, then a good opcode clears the error
        run_frame(8'hFF, 8'h12, 8'h34, 0, -1);
        run_frame(OP_WR, 8'h10, 8'hA5, 0, -1);
        // counter restart at idx 12, then a full write
        run_frame(OP_WR, 8'h11, 8'h77, 12, -1);
        run_frame(OP_WR, 8'h22, 8'h99, 0, -1);
        // reset at idx 20 of a write, then read back
        run_frame(OP_WR, 8'h33, 8'h44, 0, 20);
        run_frame(OP_RD, 8'h22, 8'h00, 0, -1);
        check_eq("rd_after_rst", 32'(got_rd), 32'h0000_0099);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0:       op = OP_RD;
                1:       op = OP_WR;
                default: op = 8'($urandom);
            endcase
            cut    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 31)) : 0;
            rst_at = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 31)) : -1;
            run_frame(op, 8'($urandom_range(0, 7)), 8'($urandom), cut, rst_at);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spi_sram_frame.md
Name: spi_sram_frame

Overview:
- SPI-slave frame engine between the 5-bit sck bit counter and the SRAM array.
- Consumes the counter's bit index and the mosi stream, then decodes a 32-bit frame: opcode, address and data.
- Issues single-cycle SRAM read/write strobes and returns read data on miso.
- Runs entirely in the sck domain.

Parameters:
- AW, 8, SRAM address width (fixed at 8 for the frame layout; other values are illegal).
- DW, 8, SRAM data width (fixed at 8 for the frame layout; other values are illegal).
- OP_RD, 8'h03, read opcode.
- OP_WR, 8'h02, write opcode.

Ports:
- sck  input  1  SPI clock; all logic is on posedge.
- rst  input  1  synchronous, active-low reset, sampled on posedge sck.
- bit_idx  input  5  frame bit index from the counter ({in1,in2,in3,in4,in5}, in1 = MSB); value k means mosi carries frame bit k this edge.
- mosi  input  1  serial data in, MSB-first.
- sram_rdata  input  DW  SRAM read data, valid the cycle after sram_re.
- miso  output  1  serial data out, registered.
- sram_addr  output  AW  registered address.
- sram_wdata  output  DW  registered write data.
- sram_we  output  1  one-cycle write strobe.
- sram_re  output  1  one-cycle read strobe.
- busy  output  1  high while a frame is past its opcode phase.
- frame_err  output  1  sticky until next opcode: last opcode was unknown.

Behaviour:
- Reset (rst==0 at posedge):
  - state=S_CMD; shift register=0.
  - miso, sram_addr, sram_wdata, sram_we, sram_re, busy, frame_err all 0.
  - Reset mid-frame aborts the frame with no strobe.
- Frame layout, MSB-first, indexed by bit_idx:
  - 0-7: opcode.
  - 8-15: address.
  - 16-23: data.
  - 24-31: trailer.
- States: S_CMD, S_ADDR, S_DATA, S_DONE, S_ERR.
- S_CMD:
  - Shift mosi in.
  - At idx 7, op={sh[6:0],mosi}.
  - OP_RD or OP_WR: go to S_ADDR, busy<=1, frame_err<=0.
  - Any other opcode: go to S_ERR, frame_err<=1, busy<=1.
- S_ADDR:
  - Shift mosi in.
  - At idx 15, sram_addr<={sh[6:0],mosi}.
  - If read: sram_re<=1 for exactly one cycle.
  - Go to S_DATA.
- S_DATA, read:
  - At idx 16, load sram_rdata into the out-shifter and set miso<=sram_rdata[7].
  - Idx 17..23 drive miso with bits 6..0 in order.
  - At idx 23, go to S_DONE.
- S_DATA, write:
  - Shift mosi in.
  - At idx 23, sram_wdata<={sh[6:0],mosi}, sram_we<=1 for one cycle.
  - Go to S_DONE.
- S_DONE:
  - Idx 24..31: miso per the optional feature.
  - At idx 31: busy<=0, go to S_CMD.
- S_ERR:
  - miso=0; no strobes.
  - At idx 31: busy<=0, go to S_CMD.
- Strobes:
  - sram_we/sram_re self-clear the next edge.
  - Never both high.
  - At most one strobe per frame.
- Resync: bit_idx==0 in any state other than S_CMD forces S_CMD.
  - That edge's mosi is taken as opcode bit 7.
  - The partial frame is dropped: no strobe, sram_addr and sram_wdata unchanged.
- bit_idx wrap 31→0 is the normal back-to-back frame case; there is no idle gap requirement.
- miso is 0 outside S_DATA-read and the S_DONE status window.

Optional Feature:
- Macro: SPI_SRAM_STATUS_EN.
- With the macro defined: at idx 24 the out-shifter loads status {frame_err, wr_done, rd_done, frame_cnt[4:0]} and shifts it MSB-first on miso over idx 24..31.
  - wr_done / rd_done: the type of the last completed frame.
  - frame_cnt: count of completed frames (S_DONE→S_CMD), wraps 31→0, cleared by reset.
- Without the macro: miso=0 during S_DONE; frame_cnt logic is absent.

Test Plan:
- Write frame 0x02,0x5A,0xC3 with idx 0..31 → single sram_we pulse after idx 23 edge; sram_addr=0x5A; sram_wdata=0xC3; busy falls after idx 31.
- Read frame 0x03,0x5A, sram_rdata=0xC3 held the cycle after sram_re → sram_re one cycle after idx 15; miso over idx 16..23 = 1,1,0,0,0,0,1,1; no sram_we.
- Opcode 0xFF → frame_err=1 from the idx 7 edge; no strobes; miso=0; next valid opcode clears frame_err at its idx 7.
- Write frame with bit_idx forced to 0 at idx 12 → no strobe; sram_addr unchanged; new opcode captured and the following full write completes normally.
- rst=0 at idx 20 of a write → all outputs 0 next edge; no sram_we; next frame from idx 0 works.
- SPI_SRAM_STATUS_EN on: write, then read, then trailer → miso over idx 24..31 = 0,0,1,0,0,0,1,0 (rd_done, frame_cnt=2) on the second frame.
